// File: rtl/mure_pkg.sv
// Shared architectural widths for the retire path.
package mure_pkg;
  parameter int XLEN      = 64;
  parameter int CAUSE_LEN = 6;
endpackage

// File: rtl/mure_retire_serializer_if.sv
// Commit-port and serialized-output bundle for mure_retire_serializer.
interface mure_retire_serializer_if #(
  parameter int NrRetiredInstr = 2,
  parameter int XLEN           = mure_pkg::XLEN,
  parameter int CauseLen       = mure_pkg::CAUSE_LEN
);
  logic [NrRetiredInstr-1:0]      valids_i;
  logic [NrRetiredInstr*XLEN-1:0] pc_i;
  logic [NrRetiredInstr*32-1:0]   inst_i;
  logic                           exception_i;
  logic                           interrupt_i;
  logic [CauseLen-1:0]            cause_i;
  logic [XLEN-1:0]                tval_i;
  logic [XLEN-1:0]                epc_i;

  logic                           out_valid_o;
  logic                           out_ready_i;
  logic                           out_iretired_o;
  logic                           out_exception_o;
  logic                           out_interrupt_o;
  logic [31:0]                    out_inst_o;
  logic [XLEN-1:0]                out_pc_o;
  logic [CauseLen-1:0]            out_cause_o;
  logic [XLEN-1:0]                out_tval_o;
  logic                           overflow_o;
  logic [15:0]                    drop_cnt_o;

  modport master (
    output valids_i, pc_i, inst_i, exception_i, interrupt_i, cause_i, tval_i, epc_i, out_ready_i,
    input  out_valid_o, out_iretired_o, out_exception_o, out_interrupt_o, out_inst_o,
           out_pc_o, out_cause_o, out_tval_o, overflow_o, drop_cnt_o
  );

  modport slave (
    input  valids_i, pc_i, inst_i, exception_i, interrupt_i, cause_i, tval_i, epc_i, out_ready_i,
    output out_valid_o, out_iretired_o, out_exception_o, out_interrupt_o, out_inst_o,
           out_pc_o, out_cause_o, out_tval_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/mure_retire_serializer.sv
// Compacts up to NrRetiredInstr commits per cycle into a FIFO and drains one entry per handshake.
// Optional MURE_DROP_CNT_EN adds a saturating counter of refused commit groups.

// Per-slot entry builder: write offset within the group and the entry itself.
module mure_retire_lane #(
  parameter int NrRetiredInstr = 2,
  parameter int Lane           = 0,
  parameter int XLEN           = 64,
  parameter int CauseLen       = 6,
  parameter int OffW           = 2,
  parameter int EntW           = 35 + 2*XLEN + CauseLen
) (
  input  logic [NrRetiredInstr-1:0] valids_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [31:0]               inst_i,
  input  logic                      exception_i,
  input  logic                      interrupt_i,
  input  logic [CauseLen-1:0]       cause_i,
  input  logic [XLEN-1:0]           tval_i,
  output logic [OffW-1:0]           offset_o,
  output logic [EntW-1:0]           entry_o
);
  typedef struct packed {
    logic                iretired;
    logic                exception;
    logic                interrupt;
    logic [31:0]         inst;
    logic [XLEN-1:0]     pc;
    logic [CauseLen-1:0] cause;
    logic [XLEN-1:0]     tval;
  } entry_t;

  entry_t ent;
  logic   is_last;

  always_comb begin
    offset_o = '0;
    is_last  = valids_i[Lane];
    for (int j = 0; j < NrRetiredInstr; j++) begin
      if (j < Lane && valids_i[j]) offset_o = offset_o + OffW'(1);
      if (j > Lane && valids_i[j]) is_last = 1'b0;
    end
    ent          = '0;
    ent.iretired = 1'b1;
    ent.inst     = inst_i;
    ent.pc       = pc_i;
    // trap sideband belongs only to the youngest retiring instruction
    if (is_last && exception_i) begin
      ent.exception = 1'b1;
      ent.interrupt = interrupt_i;
      ent.cause     = cause_i;
      ent.tval      = tval_i;
    end
  end

  assign entry_o = ent;
endmodule

module mure_retire_serializer #(
  parameter int NrRetiredInstr = 2,
  parameter int FifoDepth      = 16,
  parameter int XLEN           = mure_pkg::XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  mure_retire_serializer_if.slave  bus
);
  localparam int CauseLen = mure_pkg::CAUSE_LEN;
  localparam int AW       = $clog2(FifoDepth);
  localparam int CW       = AW + 1;
  localparam int OffW     = $clog2(NrRetiredInstr) + 1;
  localparam int EntW     = 35 + 2*XLEN + CauseLen;

  typedef logic [AW-1:0] ptr_t;
  typedef struct packed {
    logic                iretired;
    logic                exception;
    logic                interrupt;
    logic [31:0]         inst;
    logic [XLEN-1:0]     pc;
    logic [CauseLen-1:0] cause;
    logic [XLEN-1:0]     tval;
  } entry_t;

  entry_t                                mem [FifoDepth];
  ptr_t                                  wptr, rptr;
  logic [CW-1:0]                         occ;
  logic                                  overflow_q;
  logic [NrRetiredInstr-1:0][OffW-1:0]   lane_off;
  logic [NrRetiredInstr-1:0][EntW-1:0]   lane_ent;
  logic [OffW-1:0]                       m_cnt, grp;
  logic                                  trap_only, accept, push, refuse, pop;
  entry_t                                trap_ent, head;

  for (genvar g = 0; g < NrRetiredInstr; g++) begin : g_lane
    mure_retire_lane #(
      .NrRetiredInstr(NrRetiredInstr), .Lane(g), .XLEN(XLEN),
      .CauseLen(CauseLen), .OffW(OffW), .EntW(EntW)
    ) u_lane (
      .valids_i   (bus.valids_i),
      .pc_i       (bus.pc_i[g*XLEN +: XLEN]),
      .inst_i     (bus.inst_i[g*32 +: 32]),
      .exception_i(bus.exception_i),
      .interrupt_i(bus.interrupt_i),
      .cause_i    (bus.cause_i),
      .tval_i     (bus.tval_i),
      .offset_o   (lane_off[g]),
      .entry_o    (lane_ent[g])
    );
  end

  always_comb begin
    m_cnt = '0;
    for (int k = 0; k < NrRetiredInstr; k++)
      if (bus.valids_i[k]) m_cnt = m_cnt + OffW'(1);
  end

  assign trap_only = bus.exception_i && (m_cnt == '0);
  assign grp       = trap_only ? OffW'(1) : m_cnt;
  // admission is judged against start-of-cycle occupancy; a same-cycle pop earns no credit
  assign accept    = CW'(grp) <= (CW'(FifoDepth) - occ);
  assign push      = (grp != '0) && accept;
  assign refuse    = (grp != '0) && !accept;
  assign pop       = (occ != '0) && bus.out_ready_i;

  always_comb begin
    trap_ent           = '0;
    trap_ent.exception = 1'b1;
    trap_ent.interrupt = bus.interrupt_i;
    trap_ent.pc        = bus.epc_i;
    trap_ent.cause     = bus.cause_i;
    trap_ent.tval      = bus.tval_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr       <= '0;
      rptr       <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= refuse;
      if (pop)  rptr <= rptr + ptr_t'(1);
      if (push) wptr <= wptr + ptr_t'(grp);
      occ <= occ + (push ? CW'(grp) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  // storage needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      if (trap_only) mem[wptr] <= trap_ent;
      for (int k = 0; k < NrRetiredInstr; k++)
        if (bus.valids_i[k]) mem[wptr + ptr_t'(lane_off[k])] <= entry_t'(lane_ent[k]);
    end
  end

`ifdef MURE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            drop_cnt_q <= '0;
    else if (refuse && drop_cnt_q != '1)    drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign bus.drop_cnt_o = drop_cnt_q;
`else
  assign bus.drop_cnt_o = '0;
`endif

  assign head                = (occ != '0) ? mem[rptr] : '0;
  assign bus.out_valid_o     = (occ != '0);
  assign bus.out_iretired_o  = head.iretired;
  assign bus.out_exception_o = head.exception;
  assign bus.out_interrupt_o = head.interrupt;
  assign bus.out_inst_o      = head.inst;
  assign bus.out_pc_o        = head.pc;
  assign bus.out_cause_o     = head.cause;
  assign bus.out_tval_o      = head.tval;
  assign bus.overflow_o      = overflow_q;
endmodule

// File: tb/tb_mure_retire_serializer.sv
// Randomized + directed bench for mure_retire_serializer against a queue-based reference model.
module tb_mure_retire_serializer;
  localparam int N  = 2;
  localparam int D  = 16;
  localparam int XL = mure_pkg::XLEN;
  localparam int CL = mure_pkg::CAUSE_LEN;
`ifdef MURE_DROP_CNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  typedef struct packed {
    logic          iret;
    logic          exc;
    logic          intr;
    logic [31:0]   inst;
    logic [XL-1:0] pc;
    logic [CL-1:0] cause;
    logic [XL-1:0] tval;
  } ent_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  mure_retire_serializer_if #(.NrRetiredInstr(N), .XLEN(XL), .CauseLen(CL)) bus ();

  mure_retire_serializer #(.NrRetiredInstr(N), .FifoDepth(D), .XLEN(XL)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  ent_t        q[$];
  bit          m_ovf;
  int unsigned m_drop;
  int          n_chk, n_err;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    ent_t obs, exp;
    obs = {bus.out_iretired_o, bus.out_exception_o, bus.out_interrupt_o, bus.out_inst_o,
           bus.out_pc_o, bus.out_cause_o, bus.out_tval_o};
    exp = (q.size() != 0) ? q[0] : '0;
    chk({tag, "_valid"}, bus.out_valid_o, q.size() != 0);
    chk({tag, "_entry"}, obs, exp);
    chk({tag, "_ovf"},   bus.overflow_o, m_ovf);
    chk({tag, "_drop"},  bus.drop_cnt_o, m_drop);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [XL-1:0] p0, input logic [XL-1:0] p1,
                       input logic exc, input logic intr, input logic [CL-1:0] cause,
                       input logic [XL-1:0] tval, input logic [XL-1:0] epc, input logic rdy);
    bus.valids_i    = v;
    bus.pc_i        = {p1, p0};
    bus.inst_i      = {$urandom(), $urandom()};
    bus.exception_i = exc;
    bus.interrupt_i = intr;
    bus.cause_i     = cause;
    bus.tval_i      = tval;
    bus.epc_i       = epc;
    bus.out_ready_i = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive('0, '0, '0, 1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  // Reference: build the group from the commit rules, then apply pop and all-or-nothing push.
  task automatic model_step();
    ent_t grp[$];
    ent_t e;
    int   start_occ;
    start_occ = q.size();
    for (int k = 0; k < N; k++) begin
      if (bus.valids_i[k]) begin
        e      = '0;
        e.iret = 1'b1;
        e.pc   = bus.pc_i[k*XL +: XL];
        e.inst = bus.inst_i[k*32 +: 32];
        grp.push_back(e);
      end
    end
    if (bus.exception_i) begin
      if (grp.size() > 0) begin
        e       = grp.pop_back();
        e.exc   = 1'b1;
        e.intr  = bus.interrupt_i;
        e.cause = bus.cause_i;
        e.tval  = bus.tval_i;
        grp.push_back(e);
      end else begin
        e       = '0;
        e.exc   = 1'b1;
        e.intr  = bus.interrupt_i;
        e.pc    = bus.epc_i;
        e.cause = bus.cause_i;
        e.tval  = bus.tval_i;
        grp.push_back(e);
      end
    end
    m_ovf = (grp.size() > 0) && (grp.size() > D - start_occ);
    if (m_ovf && DropEn && m_drop < 32'hFFFF) m_drop++;
    if (start_occ != 0 && bus.out_ready_i) void'(q.pop_front());
    if (!m_ovf) foreach (grp[i]) q.push_back(grp[i]);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs(tag);
  endtask

  initial begin
    int cnt;
    int thr;
    n_chk = 0; n_err = 0; m_ovf = 0; m_drop = 0;

    // reset holds everything at zero even with live commit traffic
    drive(2'b11, 64'h10, 64'h14, 1'b1, 1'b0, 6'd3, 64'h1, 64'h2, 1'b1);
    repeat (2) @(negedge clk_i);
    check_outputs("reset");
    rst_ni = 1'b1;
    idle(1'b1);

    // two-wide commit drained in order
    drive(2'b11, 64'h100, 64'h104, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    tick("r32a");
    chk("r32_pc0", bus.out_pc_o, 64'h100);
    idle(1'b1);
    tick("r32b");
    chk("r32_pc1", bus.out_pc_o, 64'h104);
    chk("r32_iret", bus.out_iretired_o, 1'b1);
    tick("r32c");

    // exception attached to the only valid slot
    drive(2'b10, 64'h0, 64'h200, 1'b1, 1'b0, 6'd2, 64'hDEAD, 64'h0, 1'b0);
    tick("r33");
    chk("r33_pc", bus.out_pc_o, 64'h200);
    chk("r33_exc", bus.out_exception_o, 1'b1);
    chk("r33_cause", bus.out_cause_o, 6'd2);
    chk("r33_tval", bus.out_tval_o, 64'hDEAD);
    idle(1'b1);
    tick("r33d");

    // trap with no retiring instruction
    drive(2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 6'd7, 64'h55, 64'h300, 1'b0);
    tick("r34");
    chk("r34_iret", bus.out_iretired_o, 1'b0);
    chk("r34_intr", bus.out_interrupt_o, 1'b1);
    chk("r34_pc", bus.out_pc_o, 64'h300);
    chk("r34_inst", bus.out_inst_o, 32'h0);
    idle(1'b1);
    tick("r34d");

    // fill to capacity, then one more group is refused
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 64'($urandom()), 64'($urandom()), 1'b0, 1'b0, '0, '0, '0, 1'b0);
      tick("r35fill");
    end
    drive(2'b11, 64'hA0, 64'hA4, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick("r35ovf");
    chk("r35_ovf", bus.overflow_o, 1'b1);
    chk("r35_drop", bus.drop_cnt_o, DropEn ? 16'd1 : 16'd0);
    chk("r35_full", bus.out_valid_o, 1'b1);
    idle(1'b0);
    tick("r35post");
    chk("r35_pulse", bus.overflow_o, 1'b0);

    // occupancy 15: a pair is refused even though the head pops this cycle
    idle(1'b1);
    tick("r36pop");
    drive(2'b11, 64'hB0, 64'hB4, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    tick("r36push");
    chk("r36_ovf", bus.overflow_o, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid_o) cnt++;
      idle(1'b1);
      tick("r36drain");
    end
    chk("r36_occ", cnt, 14);

    // reset mid-operation with five entries queued
    drive(2'b11, 64'hC0, 64'hC4, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick("r37a");
    drive(2'b11, 64'hC8, 64'hCC, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick("r37b");
    drive(2'b01, 64'hD0, 64'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick("r37c");
    chk("r37_pre", bus.out_valid_o, 1'b1);
    idle(1'b1);
    rst_ni = 1'b0;
    #1;
    chk("r37_valid0", bus.out_valid_o, 1'b0);
    chk("r37_pc0", bus.out_pc_o, 64'h0);
    q.delete(); m_ovf = 0; m_drop = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs("r37rst");
    rst_ni = 1'b1;
    drive(2'b01, 64'h400, 64'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick("r37push");
    chk("r37_head", bus.out_pc_o, 64'h400);
    idle(1'b1);
    tick("r37pop");
    chk("r37_alone", bus.out_valid_o, 1'b0);

    // randomized traffic with drifting consumer pressure
    for (int i = 0; i < 1500; i++) begin
      case ((i / 250) % 3)
        0:       thr = 20;
        1:       thr = 55;
        default: thr = 90;
      endcase
      drive(N'($urandom()), {$urandom(), $urandom()}, {$urandom(), $urandom()},
            $urandom_range(0, 5) == 0, 1'($urandom()), CL'($urandom()),
            {$urandom(), $urandom()}, {$urandom(), $urandom()},
            $urandom_range(0, 99) < thr);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mure_retire_serializer.md
MURE_RETIRE_SERIALIZER -- requirements
Module: mure_retire_serializer

Interface
REQ-001 Parameter NrRetiredInstr, default 2, meaning number of commit ports per cycle (legal 1..4).
REQ-002 Parameter FifoDepth, default 16, meaning entry capacity of the internal queue (power of two, >= 2*NrRetiredInstr).
REQ-003 Parameter XLEN, default mure_pkg::XLEN, meaning address/tval width.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous and active-low.
REQ-006 valids_i  in  NrRetiredInstr  per-slot retire valid; slot 0 is oldest.
REQ-007 pc_i  in  NrRetiredInstr*XLEN  per-slot instruction address; slot k at bits [k*XLEN +: XLEN].
REQ-008 inst_i  in  NrRetiredInstr*32  per-slot opcode.
REQ-009 exception_i  in  1  trap taken this cycle.
REQ-010 interrupt_i  in  1  trap is an interrupt (qualifies exception_i).
REQ-011 cause_i  in  mure_pkg::CAUSE_LEN  trap cause; tval_i  in  XLEN  trap value; epc_i  in  XLEN  trap PC.
REQ-012 out_valid_o  out  1  output entry valid; out_ready_i  in  1  consumer accepts.
REQ-013 out_iretired_o, out_exception_o, out_interrupt_o  out  1 each  entry flags.
REQ-014 out_inst_o  out  32; out_pc_o  out  XLEN; out_cause_o  out  CAUSE_LEN; out_tval_o  out  XLEN.
REQ-015 overflow_o  out  1  one-cycle pulse when a commit group is dropped.
REQ-016 drop_cnt_o  out  16  saturating count of dropped groups (see Configuration).

Function
REQ-017 Each cycle, valid slots SHALL be compacted in slot order into a group of M = popcount(valids_i) entries with iretired=1.
REQ-018 If exception_i=1 and M>0, the exception/interrupt/cause/tval fields SHALL be attached to the last entry of the group only.
REQ-019 If exception_i=1 and M=0, the group SHALL be one entry: iretired=0, exception=1, pc=epc_i, inst=0.
REQ-020 Group push SHALL be all-or-nothing: the group is written iff its size <= FifoDepth minus the occupancy at the start of the cycle (the same-cycle pop is not credited).
REQ-021 On a refused group: no entry written, overflow_o=1 for the following cycle, queue contents unchanged.
REQ-022 Pop SHALL occur iff out_valid_o && out_ready_i; exactly one entry per pop, FIFO order.
REQ-023 Output fields SHALL be driven from the queue head; out_valid_o = (occupancy != 0).
REQ-024 Latency: an entry pushed on edge t SHALL be visible at the output from cycle t+1 when the queue was empty.
REQ-025 Output fields SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-026 Simultaneous push and pop SHALL update occupancy by (group size - 1); pointers wrap modulo FifoDepth.
REQ-027 Occupancy SHALL never exceed FifoDepth; at full, out_valid_o stays 1 and groups of size >= 1 are refused.

Reset
REQ-028 While rst_ni=0: occupancy, read/write pointers, overflow_o and drop_cnt_o SHALL be 0; out_valid_o=0; all out_* data fields SHALL read 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries immediately, with no pop handshake completed.

Configuration
REQ-030 Macro MURE_DROP_CNT_EN defined: drop_cnt_o increments by 1 on each refused group and saturates at 16'hFFFF.
REQ-031 Macro MURE_DROP_CNT_EN undefined: no counter register; drop_cnt_o SHALL be tied to 0; overflow_o is unaffected.

Verification
REQ-032 N=2, valids_i=2'b11, pc={0x104,0x100}, out_ready_i=1 -> output pc 0x100 then 0x104 on consecutive cycles, iretired=1.
REQ-033 valids_i=2'b10, pc slot1=0x200, exception_i=1, cause=2, tval=0xDEAD -> single entry pc 0x200, exception=1, cause 2, tval 0xDEAD.
REQ-034 valids_i=0, exception_i=1, interrupt_i=1, epc_i=0x300, cause=7 -> entry iretired=0, exception=1, interrupt=1, pc 0x300.
REQ-035 Depth 16, out_ready_i=0, 8 cycles of valids 2'b11, then one more group -> 16 entries held, 9th group refused, overflow_o pulses once, drop_cnt_o=1 with MURE_DROP_CNT_EN and 0 without it.
REQ-036 Occupancy 15, valids 2'b11 with pop in the same cycle -> group refused (no credit for the pop), occupancy 14 after the edge.
REQ-037 Occupancy 5, rst_ni pulsed low for 1 cycle -> out_valid_o=0 immediately, and the next single push appears alone at the head.
